forward_converter_32769_32768_32767: RTL and testbench

Pipelined binary-to-RNS forward converter for the moduli set {2^15+1, 2^15, 2^15-1}. It accepts a 45-bit unsigned integer and produces the three residues (x1, x2, x3) in the same order and widths consumed by the matching reverse converter. It sits at the entry of the RNS datapath, and its outputs feed the residue channels directly. Flow control is valid/ready on both sides, with a 3-stage stallable pipeline.

---
 rtl/forward_converter_32769_32768_32767.sv | 130 +++++++++++++
 tb/tb_forward_converter_32769_32768_32767.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/forward_converter_32769_32768_32767.sv
// Binary-to-RNS forward converter for moduli {2^15+1, 2^15, 2^15-1}.
// Three-stage stallable valid/ready pipeline; in_ready is the only
// combinational output and depends on out_ready through the stage enables.
module forward_converter_32769_32768_32767 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [44:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x1,
  output logic [14:0] out_x2,
  output logic [14:0] out_x3
);

  localparam int unsigned CW = 15;  // chunk width
  localparam int unsigned PW = 17;  // three-chunk sum width
  localparam int unsigned QW = 16;  // two-chunk sum width
  localparam int unsigned FW = 16;  // first fold width
  localparam int unsigned DW = 18;  // signed alternating sum width
  localparam int unsigned X1W = 16;

  localparam logic signed [DW-1:0] M1     = 18'sd32769;
  localparam logic signed [DW-1:0] TWO_M1 = 18'sd65538;

  // Stage registers
  logic          v1_q, v2_q, v3_q;
  logic [PW-1:0] p_q,  p_d;
  logic [QW-1:0] q_q,  q_d;
  logic [CW-1:0] c1_q;
  logic [CW-1:0] c0_s1_q;
  logic [FW-1:0] f_q,  f_d;
  logic signed [DW-1:0] d_q, d_d;
  logic [CW-1:0] c0_s2_q;
  logic [X1W-1:0] x1_q, x1_d;
  logic [CW-1:0]  x2_q;
  logic [CW-1:0]  x3_q, x3_d;

  logic en1_c, en2_c, en3_c;
  logic [CW-1:0] c0_c, c1_c, c2_c;
  logic [CW-1:0] x3_sum_c;

  // Stage enables: a stage advances when it is empty or its successor advances
  always_comb begin
    en3_c    = ~v3_q | out_ready;
    en2_c    = ~v2_q | en3_c;
    en1_c    = ~v1_q | en2_c;
    in_ready = en1_c & rst_n;
  end

  // Stage 1 datapath: chunk sums for the 2^15-1 and 2^15+1 channels
  always_comb begin
    c0_c = in_x[CW-1:0];
    c1_c = in_x[2*CW-1:CW];
    c2_c = in_x[3*CW-1:2*CW];
    p_d  = PW'(c0_c) + PW'(c1_c) + PW'(c2_c);
    q_d  = QW'(c0_c) + QW'(c2_c);
  end

  // Stage 2 datapath: fold the 17-bit sum once, form the signed alternating sum
  always_comb begin
    f_d = FW'(p_q[CW-1:0]) + FW'(p_q[PW-1:CW]);
    d_d = DW'(q_q) - DW'(c1_q);
  end

  // Stage 3 datapath: end-around carry with 0x7FFF -> 0, and range-correct d
  always_comb begin
    // f[15] set implies f[14:0] <= 2, so the 15-bit sum cannot overflow
    x3_sum_c = f_q[CW-1:0] + CW'(f_q[FW-1]);
    x3_d     = (x3_sum_c == 15'h7FFF) ? '0 : x3_sum_c;
    if (d_q < 0)            x1_d = X1W'(d_q + M1);
    else if (d_q >= TWO_M1) x1_d = X1W'(d_q - TWO_M1);
    else if (d_q >= M1)     x1_d = X1W'(d_q - M1);
    else                    x1_d = X1W'(d_q);
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      c1_q    <= '0;
      c0_s1_q <= '0;
    end else if (en1_c) begin
      v1_q    <= in_valid & in_ready;
      p_q     <= p_d;
      q_q     <= q_d;
      c1_q    <= c1_c;
      c0_s1_q <= c0_c;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      f_q     <= '0;
      d_q     <= '0;
      c0_s2_q <= '0;
    end else if (en2_c) begin
      v2_q    <= v1_q;
      f_q     <= f_d;
      d_q     <= d_d;
      c0_s2_q <= c0_s1_q;
    end
  end

  // Stage 3 (output) register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      x1_q <= '0;
      x2_q <= '0;
      x3_q <= '0;
    end else if (en3_c) begin
      v3_q <= v2_q;
      x1_q <= x1_d;
      x2_q <= c0_s2_q;
      x3_q <= x3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_x1    = x1_q;
  assign out_x2    = x2_q;
  assign out_x3    = x3_q;

endmodule

// File: tb/tb_forward_converter_32769_32768_32767.sv
// Randomized self-checking bench: residues via plain modulo, round trip via CRT.
module tb_forward_converter_32769_32768_32767;

  localparam longint unsigned M = 64'd35184372056064;  // 32769*32768*32767

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [44:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x1;
  logic [14:0] out_x2;
  logic [14:0] out_x3;

  forward_converter_32769_32768_32767 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x1    (out_x1),
    .out_x2    (out_x2),
    .out_x3    (out_x3)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned x;
    int              cyc;
  } item_t;

  item_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  bit    lat_en = 1'b0;
  bit    prev_stall = 1'b0;
  logic [15:0] h_x1;
  logic [14:0] h_x2, h_x3;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Chinese-remainder reconstruction, standing in for the reverse converter
  function automatic longint unsigned crt(input longint unsigned r1,
                                          input longint unsigned r2,
                                          input longint unsigned r3);
    longint unsigned t1, t2, t3;
    t1 = (r1 * 64'd16385) % 64'd32769;
    t2 = (r2 * 64'd32767) % 64'd32768;
    t3 = (r3 * 64'd16384) % 64'd32767;
    return (t1 * 64'd1073709056 + t2 * 64'd1073741823 + t3 * 64'd1073774592) % M;
  endfunction

  function automatic logic [44:0] rand45();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[44:0];
  endfunction

  // One clock cycle: drive on the falling edge, sample 1ns later, model the handshake
  task automatic step(input logic v, input logic [44:0] x, input logic rdy, output logic acc);
    item_t it;
    @(negedge clk);
    in_valid  = v;
    in_x      = x;
    out_ready = rdy;
    #1;
    acc = 1'b0;
    if (rst_n) begin
      chk("in_ready", in_ready, (sb.size() == 3 && !rdy) ? 0 : 1);
      if (sb.size() == 0) chk("idle_valid", out_valid, 0);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_x1", out_x1, h_x1);
        chk("hold_x2", out_x2, h_x2);
        chk("hold_x3", out_x3, h_x3);
      end
      if (out_valid && rdy && sb.size() > 0) begin
        it = sb.pop_front();
        chk("x1", out_x1, it.x % 64'd32769);
        chk("x2", out_x2, it.x % 64'd32768);
        chk("x3", out_x3, it.x % 64'd32767);
        if (lat_en) chk("latency", longint'(cyc - it.cyc), 3);
        if (it.x < M) chk("roundtrip", crt(out_x1, out_x2, out_x3), it.x);
      end
      prev_stall = out_valid && !rdy;
      h_x1 = out_x1;
      h_x2 = out_x2;
      h_x3 = out_x3;
      if (v && in_ready) begin
        sb.push_back('{x: longint'(x), cyc: cyc});
        acc = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    logic        acc;
    logic [44:0] dir_x [4];
    logic [44:0] words [16];
    logic [44:0] x;
    int          idx;
    int          budget;

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_x1", out_x1, 0);
    chk("rst_x2", out_x2, 0);
    chk("rst_x3", out_x3, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed corner values, one at a time with latency checked
    dir_x[0] = 45'd0;
    dir_x[1] = 45'd32768;
    dir_x[2] = '1;
    dir_x[3] = 45'd35184372056063;
    lat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, dir_x[i], 1'b1, acc);
      chk("dir_accept", acc, 1);
      repeat (5) step(1'b0, '0, 1'b1, acc);
      chk("dir_drained", sb.size(), 0);
    end
    lat_en = 1'b0;

    // Backpressure: sink stalled 5 cycles, then toggles 1,0,1,0...
    for (int i = 0; i < 16; i++) words[i] = rand45();
    idx = 0;
    budget = 0;
    while ((idx < 16 || sb.size() > 0) && budget < 200) begin
      step(idx < 16, (idx < 16) ? words[idx] : '0,
           (budget < 5) ? 1'b0 : ((budget - 5) % 2 == 0), acc);
      if (acc) idx++;
      budget++;
    end
    chk("bp_all_sent", idx, 16);
    chk("bp_drained", sb.size(), 0);

    // Reset with three words in flight
    for (int i = 0; i < 4; i++) step(1'b1, rand45(), 1'b0, acc);
    chk("rst_preload_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_x1", out_x1, 0);
    chk("midrst_x2", out_x2, 0);
    chk("midrst_x3", out_x3, 0);
    sb.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (6) step(1'b0, '0, 1'b1, acc);

    // Random round trip, X < M, random valid and ready
    idx = 0;
    budget = 0;
    x = 45'(longint'(rand45()) % M);
    while (idx < 10000 && budget < 40000) begin
      step(($urandom % 4) != 0, x, ($urandom % 5) != 0, acc);
      if (acc) begin
        idx++;
        x = 45'(longint'(rand45()) % M);
      end
      budget++;
    end
    chk("rt_all_sent", idx, 10000);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      step(1'b0, '0, 1'b1, acc);
      budget++;
    end
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
